// File: rtl/ingress_frame_packer.sv
// Packs 32-bit MAC receive beats into 128-bit words and releases only committed frames.
// First word about 3 cycles after commit; frame_ready stalls the read side, which holds its outputs.
module ingress_frame_packer #(
    parameter int DEPTH     = 256,
    parameter int HDR_DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_start,
    input  logic         rx_data_valid,
    input  logic [2:0]   rx_bytes_valid,
    input  logic [31:0]  rx_data,
    input  logic         rx_commit,
    input  logic         rx_drop,
    output logic         frame_valid,
    input  logic         frame_ready,
    output logic         frame_last,
    output logic [127:0] frame_data,
    output logic [10:0]  frame_len,
    output logic [15:0]  drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(HDR_DEPTH);
    localparam logic [AW:0] FULL_GAP = (AW+1)'(DEPTH);
    localparam logic [HW:0] LQ_GAP   = (HW+1)'(HDR_DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [HW:0] LQ_ONE   = (HW+1)'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    logic [127:0] mem [DEPTH];
    logic [10:0]  len_fifo [HDR_DEPTH];

    logic          open_q, open_d;
    logic          bad_q, bad_d;
    logic [127:0]  acc_q, acc_d;
    logic [4:0]    acc_cnt_q, acc_cnt_d;
    logic [11:0]   len_q, len_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   cmt_ptr_q, cmt_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [HW:0]   lq_wr_q, lq_wr_d;
    logic [HW:0]   lq_rd_q, lq_rd_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic [1:0]    state_q, state_d;
    logic [6:0]    rem_q, rem_d;
    logic          frame_valid_q, frame_valid_d;
    logic          frame_last_q, frame_last_d;
    logic [10:0]   frame_len_q, frame_len_d;
    logic [127:0]  frame_data_q;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [127:0]  mem_wdata;
    logic          lq_we;
    logic          lq_full;
    logic          commit_bad;
    logic          discard;
    logic [31:0]   beat_mask;
    logic [127:0]  beat_word;
    logic [4:0]    acc_sum;

    logic          rd_load;
    logic [AW-1:0] rd_addr;
    logic [10:0]   head_len;
    logic [10:0]   head_m1;

    assign lq_full = (lq_wr_q - lq_rd_q) == LQ_GAP;

    always_comb begin
        open_d     = open_q;
        bad_d      = bad_q;
        acc_d      = acc_q;
        acc_cnt_d  = acc_cnt_q;
        len_d      = len_q;
        wr_ptr_d   = wr_ptr_q;
        cmt_ptr_d  = cmt_ptr_q;
        lq_wr_d    = lq_wr_q;
        drop_cnt_d = drop_cnt_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_ptr_q[AW-1:0];
        mem_wdata  = acc_q;
        lq_we      = 1'b0;
        discard    = 1'b0;
        beat_mask  = 32'hFFFF_FFFF << {(3'd4 - rx_bytes_valid), 3'b000};
        beat_word  = '0;
        acc_sum    = '0;
        commit_bad = bad_q || lq_full ||
                     ((acc_cnt_q != 5'd0) && ((wr_ptr_q - rd_ptr_q) == FULL_GAP));

        // Close the open frame first so a same-cycle rx_start sees it already resolved.
        if (open_q && rx_commit) begin
            open_d = 1'b0;
            if (commit_bad) begin
                wr_ptr_d = cmt_ptr_q;
                discard  = 1'b1;
            end else if (len_q == 12'd0) begin
                wr_ptr_d = cmt_ptr_q;
            end else begin
                lq_we   = 1'b1;
                lq_wr_d = lq_wr_q + LQ_ONE;
                if (acc_cnt_q != 5'd0) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                end
                cmt_ptr_d = wr_ptr_d;
            end
        end else if (open_q && rx_drop) begin
            open_d   = 1'b0;
            wr_ptr_d = cmt_ptr_q;
        end

        if (rx_start) begin
            if (open_d) begin
                wr_ptr_d = cmt_ptr_q;
                discard  = 1'b1;
            end
            open_d    = 1'b1;
            bad_d     = 1'b0;
            acc_d     = '0;
            acc_cnt_d = '0;
            len_d     = '0;
        end

        if (rx_data_valid && open_d) begin
            beat_word = {rx_data & beat_mask, 96'd0} >> {acc_cnt_d[3:0], 3'b000};
            acc_d     = acc_d | beat_word;
            acc_sum   = acc_cnt_d + {2'b00, rx_bytes_valid};
            len_d     = len_d + {9'd0, rx_bytes_valid};
            if (len_d[11]) begin
                bad_d = 1'b1;
            end
            if (acc_sum[4]) begin
                if ((wr_ptr_d - rd_ptr_q) == FULL_GAP) begin
                    bad_d = 1'b1;
                end
                if (!bad_d) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_ptr_d[AW-1:0];
                    mem_wdata = acc_d;
                    wr_ptr_d  = wr_ptr_d + PTR_ONE;
                end
                acc_d     = '0;
                acc_cnt_d = '0;
            end else begin
                acc_cnt_d = acc_sum;
            end
        end

        if (discard && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_comb begin
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        lq_rd_d       = lq_rd_q;
        rem_d         = rem_q;
        frame_valid_d = frame_valid_q;
        frame_last_d  = frame_last_q;
        frame_len_d   = frame_len_q;
        rd_load       = 1'b0;
        rd_addr       = rd_ptr_q[AW-1:0];
        head_len      = len_fifo[lq_rd_q[HW-1:0]];
        head_m1       = head_len - 11'd1;

        case (state_q)
            ST_IDLE: begin
                if ((lq_wr_q != lq_rd_q) && (cmt_ptr_q != rd_ptr_q)) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                lq_rd_d       = lq_rd_q + LQ_ONE;
                rem_d         = 7'(head_m1 >> 4);
                frame_len_d   = head_len;
                frame_valid_d = 1'b1;
                frame_last_d  = (rem_d == 7'd0);
                rd_load       = 1'b1;
                state_d       = ST_STREAM;
            end
            ST_STREAM: begin
                // Fetch the next word on the accepting edge so a held-high ready sees no bubbles.
                if (frame_ready) begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    if (frame_last_q) begin
                        frame_valid_d = 1'b0;
                        frame_last_d  = 1'b0;
                        state_d       = ST_IDLE;
                    end else begin
                        rd_load      = 1'b1;
                        rd_addr      = rd_ptr_d[AW-1:0];
                        rem_d        = rem_q - 7'd1;
                        frame_last_d = (rem_q == 7'd1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (lq_we) begin
            len_fifo[lq_wr_q[HW-1:0]] <= len_q[10:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_data_q <= '0;
        end else if (rd_load) begin
            frame_data_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            open_q        <= 1'b0;
            bad_q         <= 1'b0;
            acc_q         <= '0;
            acc_cnt_q     <= '0;
            len_q         <= '0;
            wr_ptr_q      <= '0;
            cmt_ptr_q     <= '0;
            rd_ptr_q      <= '0;
            lq_wr_q       <= '0;
            lq_rd_q       <= '0;
            drop_cnt_q    <= '0;
            state_q       <= ST_IDLE;
            rem_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_last_q  <= 1'b0;
            frame_len_q   <= '0;
        end else begin
            open_q        <= open_d;
            bad_q         <= bad_d;
            acc_q         <= acc_d;
            acc_cnt_q     <= acc_cnt_d;
            len_q         <= len_d;
            wr_ptr_q      <= wr_ptr_d;
            cmt_ptr_q     <= cmt_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            lq_wr_q       <= lq_wr_d;
            lq_rd_q       <= lq_rd_d;
            drop_cnt_q    <= drop_cnt_d;
            state_q       <= state_d;
            rem_q         <= rem_d;
            frame_valid_q <= frame_valid_d;
            frame_last_q  <= frame_last_d;
            frame_len_q   <= frame_len_d;
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_last  = frame_last_q;
    assign frame_data  = frame_data_q;
    assign frame_len   = frame_len_q;
    assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_ingress_frame_packer.sv
// Randomized bench for ingress_frame_packer against a byte-queue reference model.
module tb_ingress_frame_packer;
    localparam int DEPTH = 256;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rx_start;
    logic         rx_data_valid;
    logic [2:0]   rx_bytes_valid;
    logic [31:0]  rx_data;
    logic         rx_commit;
    logic         rx_drop;
    logic         frame_valid;
    logic         frame_ready;
    logic         frame_last;
    logic [127:0] frame_data;
    logic [10:0]  frame_len;
    logic [15:0]  drop_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_bytes[$];
    int         exp_len[$];
    int         drop_exp = 0;
    int         mon_len = 0;
    int         mon_word = 0;
    bit         mon_active = 1'b0;
    int         words_seen = 0;
    int         ready_mode = 0;

    logic         stall = 1'b0;
    logic [127:0] hold_data;
    logic         hold_last;
    logic [10:0]  hold_len;

    ingress_frame_packer #(.DEPTH(DEPTH), .HDR_DEPTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_start       (rx_start),
        .rx_data_valid  (rx_data_valid),
        .rx_bytes_valid (rx_bytes_valid),
        .rx_data        (rx_data),
        .rx_commit      (rx_commit),
        .rx_drop        (rx_drop),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .frame_last     (frame_last),
        .frame_data     (frame_data),
        .frame_len      (frame_len),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int used_words();
        int u;
        u = 0;
        foreach (exp_len[i]) u += (exp_len[i] + 15) / 16;
        if (mon_active) u += (mon_len + 15) / 16 - mon_word;
        return u;
    endfunction

    // kind: 0 commit, 1 rx_drop, 2 abandon (the next rx_start discards it)
    task automatic send_frame(input int len, input int kind, input bit rnd, input bit gaps);
        logic [7:0]  fb[$];
        logic [31:0] w;
        int          n;
        for (int i = 0; i < len; i++) fb.push_back(rnd ? 8'($urandom) : 8'(i));
        rx_start = 1'b1;
        tick();
        rx_start = 1'b0;
        for (int i = 0; i < len; i += 4) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                rx_data_valid = 1'b0;
                tick();
            end
            n = (len - i >= 4) ? 4 : len - i;
            w = '0;
            for (int k = 0; k < n; k++) w[31-8*k -: 8] = fb[i+k];
            rx_data_valid  = 1'b1;
            rx_bytes_valid = 3'(n);
            rx_data        = w;
            tick();
        end
        rx_data_valid  = 1'b0;
        rx_bytes_valid = '0;
        rx_data        = '0;
        if (kind == 0) begin
            if (len > 2047 || used_words() + (len + 15) / 16 > DEPTH) begin
                drop_exp++;
            end else begin
                foreach (fb[i]) exp_bytes.push_back(fb[i]);
                exp_len.push_back(len);
            end
            rx_commit = 1'b1;
            tick();
            rx_commit = 1'b0;
        end else if (kind == 1) begin
            rx_drop = 1'b1;
            tick();
            rx_drop = 1'b0;
        end else begin
            drop_exp++;
        end
    endtask

    task automatic stray_beat();
        rx_data_valid  = 1'b1;
        rx_bytes_valid = 3'd4;
        rx_data        = $urandom;
        tick();
        rx_data_valid  = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while ((exp_len.size() != 0 || mon_active) && n < max_cycles) begin
            tick();
            n++;
        end
        if (n >= max_cycles) check_val("drain_timeout", 128'(exp_len.size()), 128'(0));
        tick();
        check_val("idle_after_drain", 128'(frame_valid), 128'(0));
    endtask

    always @(posedge clk) begin
        #1;
        frame_ready = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 1) == 1);
    end

    always @(negedge clk) begin
        logic [127:0] w;
        bit           last_exp;
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check_val("hold_valid", 128'(frame_valid), 128'(1));
                check_val("hold_data", frame_data, hold_data);
                check_val("hold_last", 128'(frame_last), 128'(hold_last));
                check_val("hold_len", 128'(frame_len), 128'(hold_len));
            end
            if (frame_valid && frame_ready) begin
                if (!mon_active) begin
                    if (exp_len.size() == 0) begin
                        check_val("spurious_word", 128'(frame_valid), 128'(0));
                    end else begin
                        mon_len    = exp_len.pop_front();
                        mon_word   = 0;
                        mon_active = 1'b1;
                    end
                end
                if (mon_active) begin
                    w = '0;
                    for (int b = 0; b < 16; b++) begin
                        if (mon_word * 16 + b < mon_len) w[127-8*b -: 8] = exp_bytes.pop_front();
                    end
                    last_exp = (mon_word == (mon_len + 15) / 16 - 1);
                    check_val("word_data", frame_data, w);
                    check_val("word_len", 128'(frame_len), 128'(mon_len));
                    check_val("word_last", 128'(frame_last), 128'(last_exp));
                    words_seen++;
                    mon_word++;
                    if (last_exp) mon_active = 1'b0;
                end
            end
            stall     = frame_valid && !frame_ready;
            hold_data = frame_data;
            hold_last = frame_last;
            hold_len  = frame_len;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int n;
        int w0;
        int len;
        int kind;
        int r;
        int prev_kind;

        rst_n          = 1'b0;
        rx_start       = 1'b0;
        rx_data_valid  = 1'b0;
        rx_bytes_valid = '0;
        rx_data        = '0;
        rx_commit      = 1'b0;
        rx_drop        = 1'b0;
        frame_ready    = 1'b0;
        repeat (3) tick();
        check_val("rst_valid", 128'(frame_valid), 128'(0));
        check_val("rst_last", 128'(frame_last), 128'(0));
        check_val("rst_data", frame_data, 128'(0));
        check_val("rst_len", 128'(frame_len), 128'(0));
        check_val("rst_drop", 128'(drop_count), 128'(0));
        rst_n = 1'b1;
        ready_mode = 1;
        repeat (2) tick();

        // 64-byte incrementing frame with first-word latency check
        send_frame(64, 0, 1'b0, 1'b0);
        lat = 1;
        while (!frame_valid && lat < 10) begin
            tick();
            lat++;
        end
        check_val("first_word_latency_le3", 128'(lat <= 3), 128'(1));
        wait_drain(200);

        send_frame(61, 0, 1'b0, 1'b0);
        wait_drain(200);

        // committed / dropped / committed
        send_frame(40, 0, 1'b1, 1'b0);
        send_frame(50, 1, 1'b1, 1'b0);
        send_frame(33, 0, 1'b1, 1'b0);
        wait_drain(300);
        check_val("abc_drop_count", 128'(drop_count), 128'(drop_exp));

        // random traffic with random backpressure, drops, abandons and stray beats
        ready_mode = 2;
        prev_kind  = 0;
        for (int f = 0; f < 30; f++) begin
            len = $urandom_range(1, 260);
            r   = $urandom_range(0, 9);
            kind = (f == 29 || r < 7) ? 0 : ((r == 7) ? 1 : 2);
            if (prev_kind != 2 && $urandom_range(0, 3) == 0) stray_beat();
            send_frame(len, kind, 1'b1, 1'b1);
            prev_kind = kind;
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_drain(4000);
        check_val("rand_drop_count", 128'(drop_count), 128'(drop_exp));

        // length boundaries
        send_frame(1, 0, 1'b1, 1'b0);
        send_frame(16, 0, 1'b1, 1'b0);
        send_frame(17, 0, 1'b1, 1'b1);
        send_frame(2047, 0, 1'b1, 1'b0);
        send_frame(2048, 0, 1'b1, 1'b0);
        wait_drain(4000);
        check_val("len_drop_count", 128'(drop_count), 128'(drop_exp));

        // 1518-byte frame under random backpressure
        w0 = words_seen;
        send_frame(1518, 0, 1'b1, 1'b0);
        wait_drain(4000);
        check_val("jumbo_word_count", 128'(words_seen - w0), 128'(95));

        // fill the buffer exactly, then overflow with one more frame
        ready_mode = 0;
        repeat (4) tick();
        send_frame(1500, 0, 1'b1, 1'b0);
        send_frame(1500, 0, 1'b1, 1'b0);
        send_frame(1088, 0, 1'b1, 1'b0);
        send_frame(1500, 0, 1'b1, 1'b0);
        tick();
        check_val("ovf_drop_count", 128'(drop_count), 128'(drop_exp));
        ready_mode = 2;
        wait_drain(5000);
        check_val("ovf_words_total", 128'(words_seen - w0), 128'(95 + 94 + 94 + 68));

        // reset in the middle of a streamed frame
        send_frame(300, 0, 1'b1, 1'b0);
        n = 0;
        while (!mon_active && n < 500) begin
            tick();
            n++;
        end
        check_val("reset_reached_stream", 128'(mon_active), 128'(1));
        rst_n = 1'b0;
        exp_bytes.delete();
        exp_len.delete();
        mon_active = 1'b0;
        drop_exp   = 0;
        tick();
        rst_n = 1'b1;
        check_val("midrst_valid", 128'(frame_valid), 128'(0));
        check_val("midrst_drop", 128'(drop_count), 128'(0));
        repeat (3) tick();
        check_val("midrst_no_output", 128'(frame_valid), 128'(0));
        send_frame(100, 0, 1'b1, 1'b1);
        wait_drain(500);
        check_val("post_rst_drop", 128'(drop_count), 128'(drop_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
